// File: rtl/decoder8.sv
// rtl/decoder8.sv - 3-to-8 active-low decoder with registered copy and optional per-line hit counters
// Hit counters are compiled in only when DECODER8_STATS_EN is defined.
module decoder8 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e3,
  input  logic             e2n,
  input  logic             e1n,
  input  logic [2:0]       in,
  output logic [7:0]       outn,
  output logic [7:0]       outn_r,
  output logic             en_r,
  input  logic [2:0]       stat_sel,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_cnt
);

  logic en;

  assign en = e3 & ~e2n & ~e1n;

  // Per-bit AND form so an unknown enable or select shows up as X on the affected lines.
  always_comb begin
    outn = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      outn[k] = ~(en & (in == 3'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outn_r <= 8'hFF;
      en_r   <= 1'b0;
    end else begin
      outn_r <= outn;
      en_r   <= en;
    end
  end

`ifdef DECODER8_STATS_EN
  logic [CNT_W-1:0] cnt [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else if (stat_clr) begin
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else if (en && (cnt[in] != {CNT_W{1'b1}})) begin
      // Saturate rather than wrap.
      cnt[in] <= cnt[in] + 1'b1;
    end
  end

  assign stat_cnt = cnt[stat_sel];
`else
  logic unused_stat;

  assign unused_stat = &{1'b0, stat_sel, stat_clr};
  assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_decoder8.sv
// tb/tb_decoder8.sv - scoreboard bench for decoder8 against an arithmetic reference model
// Counter expectations follow DECODER8_STATS_EN the same way the design does.
module tb_decoder8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, e3, e2n, e1n, stat_clr;
  logic [2:0]    in, stat_sel;
  logic [7:0]    outn, outn_r;
  logic          en_r;
  logic [CW-1:0] stat_cnt;

  typedef struct {
    int outn;
    int outn_r;
    int en_r;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_outn_r = 255;
  int   m_en_r = 0;
  int   hits[8];

`ifdef DECODER8_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder8 #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .e3(e3), .e2n(e2n), .e1n(e1n), .in(in),
    .outn(outn), .outn_r(outn_r), .en_r(en_r),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  function automatic int model_en(int a, int b, int c);
    return (a == 1 && b == 0 && c == 0) ? 1 : 0;
  endfunction

  function automatic int model_outn(int a, int b, int c, int sel);
    return model_en(a, b, c) ? 255 - (1 << sel) : 255;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle: update the model for the edge, then drive new inputs and queue the expected view.
  task automatic apply(int r, int a, int b, int c, int s, int ss, int clr);
    exp_t e;
    @(posedge clk);
    if (rst_n) begin
      m_outn_r = model_outn(e3, e2n, e1n, in);
      m_en_r   = model_en(e3, e2n, e1n);
      if (stat_clr) begin
        for (int k = 0; k < 8; k++) hits[k] = 0;
      end else if (m_en_r == 1 && hits[in] < (1 << CW) - 1) begin
        hits[in] = hits[in] + 1;
      end
    end
    #1;
    rst_n = r[0]; e3 = a[0]; e2n = b[0]; e1n = c[0];
    in = s[2:0]; stat_sel = ss[2:0]; stat_clr = clr[0];
    if (r == 0) begin
      m_outn_r = 255;
      m_en_r   = 0;
      for (int k = 0; k < 8; k++) hits[k] = 0;
    end
    e.outn   = model_outn(a, b, c, s);
    e.outn_r = m_outn_r;
    e.en_r   = m_en_r;
    e.cnt    = STATS ? hits[ss] : 0;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("outn", int'(outn), e.outn);
        chk("outn_r", int'(outn_r), e.outn_r);
        chk("en_r", int'(en_r), e.en_r);
        chk("stat_cnt", int'(stat_cnt), e.cnt);
        chk("one_cold", ($countones(outn) >= 7) ? 1 : 0, 1);
      end
    end
  end

  initial begin : stimulus
    int a, b, c;
    rst_n = 1'b0; e3 = 1'b0; e2n = 1'b1; e1n = 1'b1;
    in = 3'd0; stat_sel = 3'd0; stat_clr = 1'b0;
    for (int k = 0; k < 8; k++) hits[k] = 0;

    apply(0, 0, 1, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 4, 4, 0);
    for (int s = 0; s < 8; s++) apply(1, 1, 0, 0, s, s, 0);
    apply(1, 0, 0, 0, 3, 3, 0);
    apply(1, 1, 1, 0, 3, 3, 0);
    apply(1, 1, 0, 1, 3, 3, 0);
    apply(1, 1, 0, 0, 3, 3, 0);
    apply(1, 1, 0, 0, 5, 5, 0);
    apply(1, 1, 0, 0, 5, 5, 0);
    apply(0, 1, 0, 0, 5, 5, 0);
    apply(0, 1, 0, 0, 5, 5, 0);
    apply(1, 1, 0, 0, 5, 5, 0);
    apply(1, 1, 0, 0, 5, 5, 0);
    apply(1, 1, 0, 0, 2, 2, 1);
    for (int i = 0; i < 20; i++) apply(1, 1, 0, 0, 2, 2, 0);
    apply(1, 1, 0, 0, 2, 3, 0);
    apply(1, 1, 0, 0, 2, 2, 1);
    apply(1, 1, 0, 0, 2, 2, 0);
    apply(1, 0, 0, 0, 2, 2, 0);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 4) != 0) ? 1 : 0;
      b = ($urandom_range(0, 4) == 0) ? 1 : 0;
      c = ($urandom_range(0, 4) == 0) ? 1 : 0;
      apply(($urandom_range(0, 49) != 0) ? 1 : 0, a, b, c,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 29) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder8.md
DECODER8 -- requirements
Module: decoder8

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-output hit counter.
REQ-002 Port: clk, input, 1, single clock; all sequential logic SHALL use its rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: e3, input, 1, active-high enable.
REQ-005 Port: e2n, input, 1, active-low enable.
REQ-006 Port: e1n, input, 1, active-low enable.
REQ-007 Port: in, input, 3, binary select.
REQ-008 Port: outn, output, 8, combinational active-low one-cold decode.
REQ-009 Port: outn_r, output, 8, registered copy of outn.
REQ-010 Port: en_r, output, 1, registered copy of the combined enable.
REQ-011 Port: stat_sel, input, 3, selects which hit counter appears on stat_cnt.
REQ-012 Port: stat_clr, input, 1, synchronous clear of all hit counters.
REQ-013 Port: stat_cnt, output, CNT_W, hit count of the output line chosen by stat_sel.

Function
REQ-014 Combined enable en SHALL be e3 AND NOT e2n AND NOT e1n.
REQ-015 When en=1, outn[k] SHALL be 0 for k==in and 1 for every other k (in=0 -> 8'hFE, in=7 -> 8'h7F).
REQ-016 When en=0, outn SHALL be 8'hFF regardless of in.
REQ-017 outn SHALL be purely combinational with zero-cycle latency and no dependence on clk or rst_n.
REQ-018 outn SHALL have exactly zero or one bit low at all times.
REQ-019 On each rising clk edge, outn_r SHALL capture outn and en_r SHALL capture en (1-cycle latency).
REQ-020 Any X/Z on an enable or in bit SHALL NOT be masked; outn SHALL propagate it as X in simulation.

Reset
REQ-021 While rst_n=0, outn_r SHALL be 8'hFF and en_r SHALL be 0, asynchronously.
REQ-022 While rst_n=0, all hit counters SHALL be 0, asynchronously.
REQ-023 outn SHALL remain a live decode of the inputs during reset.
REQ-024 On rst_n deassertion, the registers SHALL resume capture on the first rising clk edge.

Configuration
REQ-025 Macro DECODER8_STATS_EN SHALL control whether the hit-counter block is compiled in.
REQ-026 With DECODER8_STATS_EN defined, there SHALL be eight CNT_W-bit counters; counter k SHALL increment on each clk edge where en=1 and in==k.
REQ-027 Each counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-028 stat_clr=1 SHALL zero all counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-029 stat_cnt SHALL be a combinational mux of counter[stat_sel].
REQ-030 Without DECODER8_STATS_EN, the ports SHALL still exist: stat_cnt SHALL be tied to 0 and stat_sel and stat_clr SHALL be ignored.

Verification
REQ-031 e3=1, e2n=0, e1n=0, sweep in 0..7 -> outn = FE, FD, FB, F7, EF, DF, BF, 7F.
REQ-032 With in=3, apply each disabling case (e3=0, or e2n=1, or e1n=1) -> outn=FF; after the next edge, outn_r=FF and en_r=0.
REQ-033 Drive rst_n low mid-operation while in=5 is enabled -> outn_r=FF and en_r=0 immediately, with outn staying DF.
REQ-034 Enabled operation with in=5, then rst_n rises -> after one edge, outn_r=DF and en_r=1.
REQ-035 With STATS_EN defined and CNT_W=4, hold in=2 enabled for 20 edges, stat_sel=2 -> stat_cnt=F (saturated) and stat_sel=3 reads 0; then stat_clr=1 together with an increment -> 0 after one edge.
REQ-036 Without STATS_EN, repeat the REQ-035 stimulus -> stat_cnt=0 throughout.
